// File: rtl/tcp_trace_pkg.sv
// rtl/tcp_trace_pkg.sv - shared opcodes, states and trace word layout for the TCP header trace engine
package tcp_trace_pkg;

    localparam int IP_ADDR_WIDTH       = 32;
    localparam int TCP_HEADER_WIDTH    = 160;
    localparam int PAYLOAD_BUF_ENTRY_W = 32;
    localparam int TRACE_W_DEF         = 2*IP_ADDR_WIDTH + TCP_HEADER_WIDTH + PAYLOAD_BUF_ENTRY_W;

    typedef enum logic [3:0] {
        OP_NOP       = 4'd0,
        OP_SEND      = 4'd1,
        OP_RECV      = 4'd2,
        OP_LOAD_MASK = 4'd3,
        OP_WAIT      = 4'd4,
        OP_FINISH    = 4'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [IP_ADDR_WIDTH-1:0]       src_ip;
        logic [IP_ADDR_WIDTH-1:0]       dst_ip;
        logic [TCP_HEADER_WIDTH-1:0]    tcp_hdr;
        logic [PAYLOAD_BUF_ENTRY_W-1:0] payload_field;
    } trace_word_t;

endpackage

// File: rtl/tcp_trace_cmp.sv
// rtl/tcp_trace_cmp.sv - masked response compare and per-receive timeout counter
module tcp_trace_cmp #(
    parameter int TRACE_W        = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               active_i,
    input  logic               rx_val_i,
    input  logic [TRACE_W-1:0] rx_data_i,
    input  logic [TRACE_W-1:0] exp_i,
    input  logic [TRACE_W-1:0] mask_i,
    output logic               rx_rdy_o,
    output logic               match_o,
    output logic               mismatch_o,
    output logic               timeout_o
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             at_limit;
    logic             equal;
    logic             accept;

    assign equal      = ((rx_data_i ^ exp_i) & mask_i) == '0;
    assign accept     = active_i && rx_val_i;
    assign at_limit   = (tmo_cnt_q == CNT_LAST);
    // A response arriving on the threshold cycle wins over the timeout.
    assign timeout_o  = active_i && !rx_val_i && at_limit;
    assign rx_rdy_o   = active_i && !timeout_o;
    assign match_o    = accept && equal;
    assign mismatch_o = accept && !equal;

    // Counter idles at zero outside RECV so every receive starts fresh.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        if (!active_i || rx_val_i || at_limit) begin
            tmo_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

endmodule

// File: rtl/tcp_hdr_trace_engine.sv
// rtl/tcp_hdr_trace_engine.sv - ROM-driven replay of TCP header transactions with masked response checking
module tcp_hdr_trace_engine
    import tcp_trace_pkg::*;
#(
    parameter int TRACE_W        = TRACE_W_DEF,
    parameter int ROM_ADDR_W     = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ERR_CNT_W      = 8,
    parameter int STOP_ON_ERR    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    output logic                  tx_val_o,
    output logic [TRACE_W-1:0]    tx_data_o,
    input  logic                  tx_rdy_i,
    input  logic                  rx_val_i,
    input  logic [TRACE_W-1:0]    rx_data_i,
    output logic                  rx_rdy_o,
    output logic [ROM_ADDR_W-1:0] rom_addr_o,
    input  logic [TRACE_W+3:0]    rom_data_i,
    output logic                  done_o,
    output logic                  error_o,
    output logic [ERR_CNT_W-1:0]  err_cnt_o
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_EXEC = ST_EXEC;
    localparam logic [1:0] S_WAIT = ST_WAIT;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]            state_q, state_d;
    logic [ROM_ADDR_W-1:0] addr_q, addr_d;
    logic [TRACE_W-1:0]    mask_q, mask_d;
    logic [15:0]           wait_cnt_q, wait_cnt_d;
    logic                  error_q, error_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic [3:0]            op;
    logic [TRACE_W-1:0]    payload;
    logic                  exec;
    logic                  recv_active;
    logic                  cmp_match, cmp_mismatch, cmp_timeout;
    logic                  advance;
    logic                  err_evt;

    assign op          = rom_data_i[TRACE_W +: 4];
    assign payload     = rom_data_i[TRACE_W-1:0];
    assign exec        = (state_q == S_EXEC);
    assign recv_active = exec && (op == OP_RECV);

    tcp_trace_cmp #(
        .TRACE_W        (TRACE_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_cmp (
        .clk        (clk),
        .rst_n      (rst),
        .active_i   (recv_active),
        .rx_val_i   (rx_val_i),
        .rx_data_i  (rx_data_i),
        .exp_i      (payload),
        .mask_i     (mask_q),
        .rx_rdy_o   (rx_rdy_o),
        .match_o    (cmp_match),
        .mismatch_o (cmp_mismatch),
        .timeout_o  (cmp_timeout)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mask_d     = mask_q;
        wait_cnt_d = wait_cnt_q;
        advance    = 1'b0;
        err_evt    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en_i) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_NOP:  advance = 1'b1;
                    OP_SEND: advance = tx_rdy_i;
                    OP_RECV: begin
                        advance = cmp_match || cmp_mismatch || cmp_timeout;
                        err_evt = cmp_mismatch || cmp_timeout;
                    end
                    OP_LOAD_MASK: begin
                        mask_d  = payload;
                        advance = 1'b1;
                    end
                    OP_WAIT: begin
                        if (payload[15:0] == 16'd0) begin
                            advance = 1'b1;
                        end else begin
                            wait_cnt_d = payload[15:0];
                            state_d    = S_WAIT;
                        end
                    end
                    OP_FINISH: state_d = S_DONE;
                    default: begin
                        err_evt = 1'b1;
                        state_d = S_DONE;
                    end
                endcase
            end
            S_WAIT: begin
                if (wait_cnt_q == 16'd1) begin
                    state_d = S_EXEC;
                    advance = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 16'd1;
                end
            end
            S_DONE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // Stop-on-error freezes the address on the failing instruction.
        if (err_evt && (STOP_ON_ERR != 0)) begin
            advance = 1'b0;
            state_d = S_DONE;
        end

        if (advance) begin
            if (&addr_q) begin
                err_evt = 1'b1;
                state_d = S_DONE;
            end else begin
                addr_d = addr_q + ROM_ADDR_W'(1);
            end
        end

        error_d   = error_q || err_evt;
        err_cnt_d = err_cnt_q;
        if (err_evt && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            mask_q     <= '1;
            wait_cnt_q <= '0;
            error_q    <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mask_q     <= mask_d;
            wait_cnt_q <= wait_cnt_d;
            error_q    <= error_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign tx_val_o   = exec && (op == OP_SEND);
    assign tx_data_o  = tx_val_o ? payload : '0;
    assign rom_addr_o = addr_q;
    assign done_o     = (state_q == S_DONE);
    assign error_o    = error_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_tcp_hdr_trace_engine.sv
// tb/tb_tcp_hdr_trace_engine.sv - self-checking bench for tcp_hdr_trace_engine
module tb_tcp_hdr_trace_engine;
    import tcp_trace_pkg::*;

    localparam int TW  = TRACE_W_DEF;
    localparam int AW  = 8;
    localparam int TMO = 16;

    typedef struct {
        logic          use_mask;
        logic [TW-1:0] mask;
        logic [TW-1:0] flip;
        int            delay;
        logic          exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic en, tx_val, tx_rdy, rx_val, rx_rdy, done, error;
    logic [TW-1:0]   tx_data, rx_data;
    logic [AW-1:0]   addr;
    logic [TW+3:0]   rom_data;
    logic [7:0]      err_cnt;

    logic en_b, tx_val_b, rx_rdy_b, done_b, error_b;
    logic [TW-1:0]   tx_data_b;
    logic [AW-1:0]   addr_b;
    logic [TW+3:0]   rom_data_b;
    logic [7:0]      err_cnt_b;

    logic [TW+3:0] rom   [256];
    logic [TW+3:0] rom_b [256];
    int            dly   [256];
    logic [TW-1:0] flp   [256];
    logic [TW-1:0] sent [$];
    logic [TW-1:0] exp_sent [$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    assign rom_data   = rom[addr];
    assign rom_data_b = rom_b[addr_b];

    tcp_hdr_trace_engine #(.ROM_ADDR_W(AW), .TIMEOUT_CYCLES(TMO), .ERR_CNT_W(8), .STOP_ON_ERR(0)) u_dut (
        .clk(clk), .rst(rst), .en_i(en),
        .tx_val_o(tx_val), .tx_data_o(tx_data), .tx_rdy_i(tx_rdy),
        .rx_val_i(rx_val), .rx_data_i(rx_data), .rx_rdy_o(rx_rdy),
        .rom_addr_o(addr), .rom_data_i(rom_data),
        .done_o(done), .error_o(error), .err_cnt_o(err_cnt)
    );

    tcp_hdr_trace_engine #(.ROM_ADDR_W(AW), .TIMEOUT_CYCLES(TMO), .ERR_CNT_W(8), .STOP_ON_ERR(1)) u_dut_stop (
        .clk(clk), .rst(rst), .en_i(en_b),
        .tx_val_o(tx_val_b), .tx_data_o(tx_data_b), .tx_rdy_i(1'b0),
        .rx_val_i(1'b0), .rx_data_i('0), .rx_rdy_o(rx_rdy_b),
        .rom_addr_o(addr_b), .rom_data_i(rom_data_b),
        .done_o(done_b), .error_o(error_b), .err_cnt_o(err_cnt_b)
    );

    task automatic chk(input string name, input logic [TW+3:0] act, input logic [TW+3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [TW+3:0] mk(input logic [3:0] op, input logic [TW-1:0] pl);
        return {op, pl};
    endfunction

    function automatic logic [TW-1:0] rnd();
        logic [TW-1:0] r;
        for (int i = 0; i < TW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic fill(input logic [TW+3:0] w);
        for (int i = 0; i < 256; i++) begin
            rom[i] = w;
            rom_b[i] = w;
            dly[i] = 1000;
            flp[i] = '0;
        end
    endtask

    task automatic do_reset();
        en = 1'b0; en_b = 1'b0; tx_rdy = 1'b0; rx_val = 1'b0; rx_data = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Drives one run of the main engine: random or constant tx_rdy, and responses per planned address.
    task automatic run_prog(input bit rand_rdy, input int budget, output bit finished);
        int cyc;
        logic [AW-1:0] prev;
        sent.delete();
        finished = 1'b0;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        cyc = 0;
        prev = addr;
        for (int t = 0; t < budget; t++) begin
            if (done) begin
                finished = 1'b1;
                break;
            end
            if (addr != prev) begin
                cyc = 0;
                prev = addr;
            end
            tx_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rom[addr][TW+3:TW] == 4'd2 && cyc >= dly[addr]) begin
                rx_val = 1'b1;
                rx_data = rom[addr][TW-1:0] ^ flp[addr];
            end else begin
                rx_val = 1'b0;
            end
            #1;
            if (tx_val && tx_rdy) sent.push_back(tx_data);
            cyc++;
            @(negedge clk);
        end
        tx_rdy = 1'b0;
        rx_val = 1'b0;
    endtask

    initial begin
        vec_t vt [8];
        logic [TW-1:0] ones, zero, one, seq_clr, seq_bit, pl, a_word, b_word, m_model, f;
        trace_word_t syn, synack;
        bit fin;
        int exp_errs, nops, k, r;

        ones = '1; zero = '0; one = 1;
        seq_clr = '1;
        seq_clr[159:128] = 32'h0;
        seq_bit = one << 140;

        vt[0] = '{1'b0, ones,    zero,         0,  1'b0};
        vt[1] = '{1'b1, seq_clr, seq_bit,      2,  1'b0};
        vt[2] = '{1'b0, ones,    seq_bit,      2,  1'b1};
        vt[3] = '{1'b0, ones,    zero,         15, 1'b0};
        vt[4] = '{1'b0, ones,    zero,         16, 1'b1};
        vt[5] = '{1'b1, zero,    ones,         1,  1'b0};
        vt[6] = '{1'b1, seq_clr, one,          0,  1'b1};
        vt[7] = '{1'b1, seq_clr, one << 255,   3,  1'b1};

        // Reset state, with a non-zero SEND word sitting at address 0.
        fill(mk(OP_FINISH, '0));
        rom[0] = mk(OP_SEND, rnd());
        en = 1'b0; en_b = 1'b0; tx_rdy = 1'b0; rx_val = 1'b0; rx_data = '0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx_val", tx_val, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_rx_rdy", rx_rdy, 0);
        chk("rst_addr", addr, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_cnt", err_cnt, 0);

        // SEND held through three stalled cycles.
        a_word = rnd();
        fill(mk(OP_FINISH, '0));
        rom[0] = mk(OP_SEND, a_word);
        do_reset();
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx_rdy = (i == 3);
            #1;
            chk($sformatf("stall%0d_tx_val", i), tx_val, 1);
            chk($sformatf("stall%0d_tx_data", i), tx_data, a_word);
            chk($sformatf("stall%0d_addr", i), addr, 0);
            @(negedge clk);
        end
        tx_rdy = 1'b0;
        chk("stall_addr_after", addr, 1);
        @(negedge clk);
        chk("stall_done", done, 1);

        // SYN out, SYN-ACK back, FINISH.
        syn = '0;
        syn.src_ip = 32'h0a000001; syn.dst_ip = 32'h0a000002;
        syn.tcp_hdr = {16'd1234, 16'd80, 32'h0000_1000, 32'h0, 4'd5, 6'd0, 6'b000010, 16'hffff, 16'h0, 16'h0};
        synack = '0;
        synack.src_ip = 32'h0a000002; synack.dst_ip = 32'h0a000001;
        synack.tcp_hdr = {16'd80, 16'd1234, 32'h0000_9000, 32'h0000_1001, 4'd5, 6'd0, 6'b010010, 16'hffff, 16'h0, 16'h0};
        fill(mk(OP_FINISH, '0));
        rom[0] = mk(OP_SEND, syn);
        rom[1] = mk(OP_RECV, synack);
        dly[1] = 2;
        do_reset();
        run_prog(1'b0, 200, fin);
        chk("syn_finished", fin, 1);
        chk("syn_sent_cnt", sent.size(), 1);
        if (sent.size() > 0) chk("syn_sent_word", sent[0], syn);
        chk("syn_error", error, 0);
        chk("syn_err_cnt", err_cnt, 0);

        // Table of single-RECV vectors: mask load, flip pattern, response delay.
        for (int v = 0; v < 8; v++) begin
            fill(mk(OP_FINISH, '0));
            rom[0] = vt[v].use_mask ? mk(OP_LOAD_MASK, vt[v].mask) : mk(OP_NOP, rnd());
            rom[1] = mk(OP_RECV, rnd());
            dly[1] = vt[v].delay;
            flp[1] = vt[v].flip;
            do_reset();
            run_prog(1'b0, 200, fin);
            chk($sformatf("vec%0d_finished", v), fin, 1);
            chk($sformatf("vec%0d_error", v), error, vt[v].exp_err);
            chk($sformatf("vec%0d_err_cnt", v), err_cnt, 8'(vt[v].exp_err));
            chk($sformatf("vec%0d_addr", v), addr, 2);
        end

        // Timeout on the main engine: rx_rdy drops on the 16th cycle, error follows.
        fill(mk(OP_FINISH, '0));
        rom[0] = mk(OP_RECV, rnd());
        rom_b[0] = rom[0];
        do_reset();
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (c == 15) chk("tmo_rdy_c15", rx_rdy, 1);
            if (c == 16) chk("tmo_rdy_c16", rx_rdy, 0);
            if (c == 16) chk("tmo_err_c16", error, 0);
            @(negedge clk);
        end
        chk("tmo_error", error, 1);
        chk("tmo_err_cnt", err_cnt, 1);
        chk("tmo_addr", addr, 1);
        @(negedge clk);
        chk("tmo_done", done, 1);

        // Same timeout with stop-on-error: done the cycle after, address frozen.
        do_reset();
        en_b = 1'b1;
        @(negedge clk);
        en_b = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (c == 16) chk("stop_done_c16", done_b, 0);
            @(negedge clk);
        end
        chk("stop_done", done_b, 1);
        chk("stop_addr", addr_b, 0);
        chk("stop_error", error_b, 1);
        chk("stop_err_cnt", err_cnt_b, 1);

        // WAIT 5 then an illegal op.
        fill(mk(OP_FINISH, '0));
        rom[0] = mk(OP_WAIT, TW'(5));
        rom[1] = mk(4'd7, rnd());
        do_reset();
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("wait_c%0d_addr", c), addr, 0);
            @(negedge clk);
        end
        chk("wait_c7_addr", addr, 1);
        chk("wait_c7_done", done, 0);
        @(negedge clk);
        chk("illegal_done", done, 1);
        chk("illegal_error", error, 1);
        chk("illegal_err_cnt", err_cnt, 1);
        chk("illegal_addr", addr, 1);

        // Reset while a SEND is pending, then replay from address 0.
        a_word = rnd();
        b_word = rnd();
        fill(mk(OP_FINISH, '0));
        rom[0] = mk(OP_SEND, a_word);
        rom[1] = mk(OP_SEND, b_word);
        do_reset();
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        tx_rdy = 1'b1;
        @(negedge clk);
        tx_rdy = 1'b0;
        #1;
        chk("mid_addr_pre", addr, 1);
        chk("mid_tx_val_pre", tx_val, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_tx_val_rst", tx_val, 0);
        chk("mid_addr_rst", addr, 0);
        @(negedge clk);
        rst = 1'b1;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        #1;
        chk("mid_restart_addr", addr, 0);
        chk("mid_restart_data", tx_data, a_word);

        // Address overrun on a ROM full of NOPs.
        fill(mk(OP_NOP, '0));
        do_reset();
        run_prog(1'b0, 400, fin);
        chk("ovr_finished", fin, 1);
        chk("ovr_error", error, 1);
        chk("ovr_err_cnt", err_cnt, 1);
        chk("ovr_addr", addr, 255);

        // Error counter saturation: every word is a failing RECV.
        fill(mk(OP_RECV, '0));
        for (int i = 0; i < 256; i++) begin
            dly[i] = 0;
            flp[i] = ones;
        end
        do_reset();
        run_prog(1'b0, 400, fin);
        chk("sat_finished", fin, 1);
        chk("sat_err_cnt", err_cnt, 8'hff);
        chk("sat_addr", addr, 255);

        // Random programs against a straight-line model of the trace.
        for (int p = 0; p < 20; p++) begin
            fill(mk(OP_FINISH, '0));
            exp_sent.delete();
            m_model = ones;
            exp_errs = 0;
            nops = 10;
            for (int i = 0; i < nops; i++) begin
                k = $urandom_range(0, 4);
                pl = rnd();
                case (k)
                    0: rom[i] = mk(OP_NOP, pl);
                    1: begin
                        rom[i] = mk(OP_SEND, pl);
                        exp_sent.push_back(pl);
                    end
                    2: begin
                        rom[i] = mk(OP_RECV, pl);
                        r = $urandom_range(0, 9);
                        dly[i] = (r < 7) ? $urandom_range(0, 6) : ((r == 7) ? 15 : 1000);
                        r = $urandom_range(0, 2);
                        f = (r == 0) ? zero : ((r == 1) ? (one << $urandom_range(0, TW-1)) : seq_bit);
                        flp[i] = f;
                        if (dly[i] > 15 || (f & m_model) != zero) exp_errs++;
                    end
                    3: begin
                        r = $urandom_range(0, 2);
                        m_model = (r == 0) ? ones : ((r == 1) ? seq_clr : zero);
                        rom[i] = mk(OP_LOAD_MASK, m_model);
                    end
                    default: begin
                        pl[15:0] = 16'($urandom_range(0, 3));
                        rom[i] = mk(OP_WAIT, pl);
                    end
                endcase
            end
            do_reset();
            run_prog(1'b1, 1500, fin);
            chk($sformatf("rnd%0d_finished", p), fin, 1);
            chk($sformatf("rnd%0d_addr", p), addr, nops);
            chk($sformatf("rnd%0d_err_cnt", p), err_cnt, 8'(exp_errs));
            chk($sformatf("rnd%0d_error", p), error, (exp_errs > 0));
            chk($sformatf("rnd%0d_sent_cnt", p), sent.size(), exp_sent.size());
            for (int i = 0; i < exp_sent.size() && i < sent.size(); i++) begin
                chk($sformatf("rnd%0d_sent%0d", p, i), sent[i], exp_sent[i]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
